regfile_wb_arbiter: RTL and testbench



---
 rtl/regfile_pkg.sv | 25 ++
 rtl/wb_fifo.sv | 82 ++++++++
 rtl/regfile_wb_arbiter.sv | 151 +++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the register-file writeback arbiter.
//   WIDTH / REG_COUNT / REG_BITS : default datapath and register-index sizes
//   wb_req_t                     : one queued write (register index + data)
//   grant_t                      : which source owns the regfile write port
// ---------------------------------------------------------------------------
package regfile_pkg;

   localparam int WIDTH     = 32;
   localparam int REG_COUNT = 32;
   localparam int REG_BITS  = $clog2(REG_COUNT);

   typedef struct packed {
      logic [REG_BITS-1:0] idx;
      logic [WIDTH-1:0]    data;
   } wb_req_t;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_PIPE = 2'd1,
      GNT_EXT  = 2'd2
   } grant_t;

endpackage

// File: rtl/wb_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo
// Synchronous FIFO of wb_req_t used to queue out-of-band regfile writes.
// Ports:
//   clk, rst     : clock, synchronous active-high reset (empties the queue)
//   push         : enqueue push_req (ignored when full)
//   push_req     : entry to enqueue
//   pop          : dequeue the head (ignored when empty)
//   count        : occupancy 0..DEPTH
//   head         : entry at the read pointer (valid when count != 0)
//   entry_valid  : per-slot valid bit, for the pending-register compare
//   entry_reg    : per-slot destination register, for the pending compare
// ---------------------------------------------------------------------------
module wb_fifo
   import regfile_pkg::*;
#(
   parameter  int DEPTH    = 4,
   localparam int PTR_BITS = $clog2(DEPTH),
   localparam int CNT_BITS = PTR_BITS + 1
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               push,
   input  wb_req_t                            push_req,
   input  logic                               pop,
   output logic [CNT_BITS-1:0]                count,
   output wb_req_t                            head,
   output logic [DEPTH-1:0]                   entry_valid,
   output logic [DEPTH-1:0][REG_BITS-1:0]     entry_reg
);

   wb_req_t               mem [DEPTH];
   logic [PTR_BITS-1:0]   wr_ptr_reg;
   logic [PTR_BITS-1:0]   rd_ptr_reg;
   logic [CNT_BITS-1:0]   count_reg;
   logic [DEPTH-1:0]      valid_reg;
   logic                  push_ok;
   logic                  pop_ok;

   assign push_ok = push && (count_reg != CNT_BITS'(DEPTH));
   assign pop_ok  = pop  && (count_reg != '0);

   // Storage carries no reset; the valid bits alone say which slots are live.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr_reg] <= push_req;
      end
   end

   // Pointers are PTR_BITS wide, so they wrap modulo DEPTH for free.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         valid_reg  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg            <= wr_ptr_reg + 1'b1;
            valid_reg[wr_ptr_reg] <= 1'b1;
         end
         if (pop_ok) begin
            rd_ptr_reg            <= rd_ptr_reg + 1'b1;
            valid_reg[rd_ptr_reg] <= 1'b0;
         end
         case ({push_ok, pop_ok})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign count       = count_reg;
   assign head        = mem[rd_ptr_reg];
   assign entry_valid = valid_reg;

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign entry_reg[gi] = mem[gi].idx;
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
// Shares the regfile's single write port between the pipeline WB stage
// (default winner, no backpressure) and an out-of-band writer that queues
// into a small FIFO via valid/ready. A starvation counter forces the pipeline
// to yield for one cycle; pending flags let decode stall on queued writes.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   pipe_wb_en/_reg/_data       : pipeline writeback request
//   ext_valid/ext_ready/ext_reg/ext_data : out-of-band request handshake
//   rf_write_en/_reg/_data      : regfile write port
//   stall_pipe                  : pipeline must hold and re-present its write
//   rs1, rs2, rd / *_pend       : decode indices and queued-write hits
//   fifo_count                  : queue occupancy
// Optional build macro:
//   REGFILE_WB_BYPASS_EN : with an idle arbiter, an out-of-band request is
//                          written straight through in the same cycle.
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
   parameter  int WIDTH        = 32,
   parameter  int REG_COUNT    = 32,
   parameter  int REG_BITS     = $clog2(REG_COUNT),
   parameter  int FIFO_DEPTH   = 4,
   parameter  int STARVE_LIMIT = 8,
   localparam int CNT_BITS     = $clog2(FIFO_DEPTH) + 1,
   localparam int STARVE_BITS  = $clog2(STARVE_LIMIT + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                pipe_wb_en,
   input  logic [REG_BITS-1:0] pipe_wb_reg,
   input  logic [WIDTH-1:0]    pipe_wb_data,
   input  logic                ext_valid,
   output logic                ext_ready,
   input  logic [REG_BITS-1:0] ext_reg,
   input  logic [WIDTH-1:0]    ext_data,
   output logic                rf_write_en,
   output logic [REG_BITS-1:0] rf_write_reg,
   output logic [WIDTH-1:0]    rf_write_data,
   output logic                stall_pipe,
   input  logic [REG_BITS-1:0] rs1,
   input  logic [REG_BITS-1:0] rs2,
   input  logic [REG_BITS-1:0] rd,
   output logic                rs1_pend,
   output logic                rs2_pend,
   output logic                rd_pend,
   output logic [CNT_BITS-1:0] fifo_count
);
   import regfile_pkg::*;

   logic [CNT_BITS-1:0]                  count;
   wb_req_t                              head;
   wb_req_t                              push_req;
   logic [FIFO_DEPTH-1:0]                entry_valid;
   logic [FIFO_DEPTH-1:0][REG_BITS-1:0]  entry_reg;
   logic                                 empty;
   logic                                 push;
   logic                                 pop;
   logic                                 bypass;
   grant_t                               grant;
   logic [STARVE_BITS-1:0]               starve_cnt_reg;
   logic [FIFO_DEPTH-1:0]                rs1_hit;
   logic [FIFO_DEPTH-1:0]                rs2_hit;
   logic [FIFO_DEPTH-1:0]                rd_hit;

   assign empty      = (count == '0);
   assign ext_ready  = !rst && (count != CNT_BITS'(FIFO_DEPTH));
   assign stall_pipe = !rst && !empty && (starve_cnt_reg == STARVE_BITS'(STARVE_LIMIT));
   assign fifo_count = count;

   always_comb begin
      grant  = GNT_NONE;
      bypass = 1'b0;
      if (!rst) begin
         if (stall_pipe) begin
            grant = GNT_EXT;
         end else if (pipe_wb_en && (pipe_wb_reg != '0)) begin
            grant = GNT_PIPE;
         end else if (!empty) begin
            grant = GNT_EXT;
         end
`ifdef REGFILE_WB_BYPASS_EN
         else if (ext_valid && (ext_reg != '0)) begin
            // Idle arbiter: write the request through instead of queueing it.
            grant  = GNT_EXT;
            bypass = 1'b1;
         end
`endif
      end
   end

   always_comb begin
      rf_write_en   = 1'b0;
      rf_write_reg  = '0;
      rf_write_data = '0;
      case (grant)
         GNT_PIPE: begin
            rf_write_en   = 1'b1;
            rf_write_reg  = pipe_wb_reg;
            rf_write_data = pipe_wb_data;
         end
         GNT_EXT: begin
            rf_write_en   = 1'b1;
            rf_write_reg  = bypass ? ext_reg  : head.idx;
            rf_write_data = bypass ? ext_data : head.data;
         end
         default: ;
      endcase
   end

   // Writes to x0 complete the handshake but are simply dropped.
   assign push          = ext_valid && ext_ready && (ext_reg != '0) && !bypass;
   assign pop           = (grant == GNT_EXT) && !bypass;
   assign push_req.idx  = ext_reg;
   assign push_req.data = ext_data;

   wb_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push        (push),
      .push_req    (push_req),
      .pop         (pop),
      .count       (count),
      .head        (head),
      .entry_valid (entry_valid),
      .entry_reg   (entry_reg)
   );

   // Counts cycles the head has waited; saturates so stall_pipe holds until
   // the forced pop clears it.
   always_ff @(posedge clk) begin
      if (rst || pop || empty) begin
         starve_cnt_reg <= '0;
      end else if (starve_cnt_reg != STARVE_BITS'(STARVE_LIMIT)) begin
         starve_cnt_reg <= starve_cnt_reg + 1'b1;
      end
   end

   for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_pend
      assign rs1_hit[gi] = entry_valid[gi] && (entry_reg[gi] == rs1);
      assign rs2_hit[gi] = entry_valid[gi] && (entry_reg[gi] == rs2);
      assign rd_hit[gi]  = entry_valid[gi] && (entry_reg[gi] == rd);
   end

   assign rs1_pend = !rst && (rs1 != '0) && (|rs1_hit);
   assign rs2_pend = !rst && (rs2 != '0) && (|rs2_hit);
   assign rd_pend  = !rst && (rd  != '0) && (|rd_hit);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_arbiter
// Directed stimulus for regfile_wb_arbiter with hand-computed expectations.
// Inputs change 1 time unit after posedge; outputs are checked 2 units later.
// ---------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        pipe_wb_en;
   logic [4:0]  pipe_wb_reg;
   logic [31:0] pipe_wb_data;
   logic        ext_valid;
   logic        ext_ready;
   logic [4:0]  ext_reg;
   logic [31:0] ext_data;
   logic        rf_write_en;
   logic [4:0]  rf_write_reg;
   logic [31:0] rf_write_data;
   logic        stall_pipe;
   logic [4:0]  rs1, rs2, rd;
   logic        rs1_pend, rs2_pend, rd_pend;
   logic [2:0]  fifo_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   regfile_wb_arbiter dut (
      .clk           (clk),
      .rst           (rst),
      .pipe_wb_en    (pipe_wb_en),
      .pipe_wb_reg   (pipe_wb_reg),
      .pipe_wb_data  (pipe_wb_data),
      .ext_valid     (ext_valid),
      .ext_ready     (ext_ready),
      .ext_reg       (ext_reg),
      .ext_data      (ext_data),
      .rf_write_en   (rf_write_en),
      .rf_write_reg  (rf_write_reg),
      .rf_write_data (rf_write_data),
      .stall_pipe    (stall_pipe),
      .rs1           (rs1),
      .rs2           (rs2),
      .rd            (rd),
      .rs1_pend      (rs1_pend),
      .rs2_pend      (rs2_pend),
      .rd_pend       (rd_pend),
      .fifo_count    (fifo_count)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      pipe_wb_en   = 1'b0;
      pipe_wb_reg  = '0;
      pipe_wb_data = '0;
      ext_valid    = 1'b0;
      ext_reg      = '0;
      ext_data     = '0;
   endtask

   task automatic chk_write(input string tag, input logic en, input logic [4:0] r,
                            input logic [31:0] d);
      chk({tag, "_en"},   rf_write_en,   en);
      chk({tag, "_reg"},  rf_write_reg,  r);
      chk({tag, "_data"}, rf_write_data, d);
   endtask

   initial begin
      rst = 1'b1;
      rs1 = '0; rs2 = '0; rd = '0;
      idle();

      // ---- reset and idle ----
      step();
      step();
      #2;
      chk("rst_ready",  ext_ready,   1'b0);
      chk("rst_wen",    rf_write_en, 1'b0);
      chk("rst_stall",  stall_pipe,  1'b0);
      chk("rst_count",  fifo_count,  3'd0);
      rst = 1'b0;
      rs1 = 5'd6; rs2 = 5'd5; rd = 5'd1;
      #2;
      chk("idle_ready", ext_ready,   1'b1);
      chk_write("idle", 1'b0, 5'd0, 32'd0);
      chk("idle_count", fifo_count,  3'd0);
      chk("idle_pend",  {rs1_pend, rs2_pend, rd_pend}, 3'b000);
      $display("reset/idle: count=%0d ready=%0b", fifo_count, ext_ready);

      // ---- pipe x5 and ext x6 in the same cycle ----
      step();
      pipe_wb_en = 1'b1; pipe_wb_reg = 5'd5; pipe_wb_data = 32'hDEADBEEF;
      ext_valid  = 1'b1; ext_reg     = 5'd6; ext_data     = 32'h12345678;
      rs1 = 5'd6;
      #2;
      chk_write("both_pipe", 1'b1, 5'd5, 32'hDEADBEEF);
      chk("both_ready",     ext_ready, 1'b1);
      chk("both_rs1_pend0", rs1_pend,  1'b0);
      $display("pipe x5 + ext x6: rf_reg=%0d data=%h", rf_write_reg, rf_write_data);
      step();
      idle();
      #2;
      chk("queued_count",   fifo_count, 3'd1);
      chk("queued_rs1pend", rs1_pend,   1'b1);
      chk_write("queued_pop", 1'b1, 5'd6, 32'h12345678);
      $display("ext x6 pop: rf_reg=%0d data=%h", rf_write_reg, rf_write_data);
      step();
      #2;
      chk("popped_count", fifo_count, 3'd0);
      chk("popped_pend",  rs1_pend,   1'b0);
      chk_write("popped", 1'b0, 5'd0, 32'd0);

      // ---- starvation: continuous pipe writes, 4 ext pushes ----
      rd = 5'd8; rs2 = 5'd12;
      for (int k = 0; k <= 9; k++) begin
         step();
         pipe_wb_en = 1'b1; pipe_wb_reg = 5'd7; pipe_wb_data = 32'h100 + k;
         ext_valid  = (k <= 4); ext_reg = 5'(8 + k); ext_data = 32'hA0 + k;
         #2;
         chk($sformatf("starve%0d_count", k), fifo_count, (k < 4) ? 3'(k) : 3'd4);
         chk($sformatf("starve%0d_ready", k), ext_ready,  k < 4);
         chk($sformatf("starve%0d_stall", k), stall_pipe, k == 9);
         chk($sformatf("starve%0d_rdpend", k), rd_pend,   (k >= 1));
         chk($sformatf("starve%0d_rs2pend", k), rs2_pend, 1'b0);
         if (k < 9) chk_write($sformatf("starve%0d", k), 1'b1, 5'd7, 32'h100 + k);
         else       chk_write("starve9_forced", 1'b1, 5'd8, 32'hA0);
         $display("starve cycle %0d: count=%0d stall=%0b rf_reg=%0d data=%h",
                  k, fifo_count, stall_pipe, rf_write_reg, rf_write_data);
      end
      step();
      ext_valid = 1'b0;
      pipe_wb_data = 32'h109;
      #2;
      chk("held_stall",  stall_pipe, 1'b0);
      chk("held_count",  fifo_count, 3'd3);
      chk("held_rdpend", rd_pend,    1'b0);
      chk_write("held", 1'b1, 5'd7, 32'h109);
      $display("held pipe write: rf_reg=%0d data=%h", rf_write_reg, rf_write_data);
      step();
      idle();
      #2;
      chk_write("drain1", 1'b1, 5'd9, 32'hA1);
      step();
      #2;
      chk_write("drain2", 1'b1, 5'd10, 32'hA2);
      step();
      #2;
      chk_write("drain3", 1'b1, 5'd11, 32'hA3);
      step();
      #2;
      chk("drained_count", fifo_count, 3'd0);
      chk_write("drained", 1'b0, 5'd0, 32'd0);
      $display("drain done: count=%0d", fifo_count);

      // ---- writes to x0 from both sides ----
      step();
      pipe_wb_en = 1'b1; pipe_wb_reg = 5'd0; pipe_wb_data = 32'h66;
      ext_valid  = 1'b1; ext_reg     = 5'd0; ext_data     = 32'h55;
      rs1 = 5'd0;
      #2;
      chk_write("x0", 1'b0, 5'd0, 32'd0);
      chk("x0_ready", ext_ready, 1'b1);
      chk("x0_pend",  rs1_pend,  1'b0);
      step();
      idle();
      #2;
      chk("x0_count", fifo_count, 3'd0);
      chk("x0_wen",   rf_write_en, 1'b0);
      $display("x0 writes: count=%0d wen=%0b", fifo_count, rf_write_en);

      // ---- reset with 3 queued entries ----
      rd = 5'd13;
      for (int k = 0; k < 3; k++) begin
         step();
         pipe_wb_en = 1'b1; pipe_wb_reg = 5'd1; pipe_wb_data = 32'h77;
         ext_valid  = 1'b1; ext_reg = 5'(13 + k); ext_data = 32'hB0 + k;
         #2;
         chk($sformatf("fill%0d_count", k), fifo_count, 3'(k));
      end
      chk("fill_rdpend", rd_pend, 1'b1);
      step();
      rst = 1'b1;
      ext_reg = 5'd16;
      #2;
      chk("rstq_count", fifo_count, 3'd3);
      chk("rstq_wen",   rf_write_en, 1'b0);
      chk("rstq_ready", ext_ready,   1'b0);
      chk("rstq_stall", stall_pipe,  1'b0);
      chk("rstq_pend",  rd_pend,     1'b0);
      step();
      rst = 1'b0;
      idle();
      #2;
      chk("postrst_count", fifo_count, 3'd0);
      chk("postrst_wen",   rf_write_en, 1'b0);
      chk("postrst_pend",  rd_pend,     1'b0);
      $display("reset with queue: count=%0d wen=%0b", fifo_count, rf_write_en);

      // ---- idle arbiter, ext x11 = 7 ----
      step();
      ext_valid = 1'b1; ext_reg = 5'd11; ext_data = 32'd7;
      #2;
`ifdef REGFILE_WB_BYPASS_EN
      chk_write("bypass", 1'b1, 5'd11, 32'd7);
      step();
      idle();
      #2;
      chk("bypass_count", fifo_count, 3'd0);
      chk("bypass_after_wen", rf_write_en, 1'b0);
`else
      chk_write("nobypass", 1'b0, 5'd0, 32'd0);
      chk("nobypass_count0", fifo_count, 3'd0);
      step();
      idle();
      #2;
      chk("nobypass_count1", fifo_count, 3'd1);
      chk_write("nobypass_pop", 1'b1, 5'd11, 32'd7);
      step();
      #2;
      chk("nobypass_count2", fifo_count, 3'd0);
`endif
      $display("ext x11=7 on idle arbiter: count=%0d", fifo_count);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
